// File: rtl/riscv_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and its datapath and memories.
interface riscv_multicycle_ctrl_if;
    logic [31:0] pc;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instruction;
    logic [31:0] ir;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_ltu;
    logic [31:0] alu_result;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_write;
    logic [1:0]  result_sel;
    logic        retired;
    logic        illegal;

    modport master (
        output pc, imem_req, ir, alu_src_imm, alu_op, dmem_req, dmem_we, reg_write,
               result_sel, retired, illegal,
        input  imem_ready, instruction, alu_zero, alu_lt, alu_ltu, alu_result, dmem_ready
    );

    modport slave (
        input  pc, imem_req, ir, alu_src_imm, alu_op, dmem_req, dmem_we, reg_write,
               result_sel, retired, illegal,
        output imem_ready, instruction, alu_zero, alu_lt, alu_ltu, alu_result, dmem_ready
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: owns pc/ir, handshakes with instruction and data memory,
// issues per-state datapath strobes and traps on illegal opcodes, misalignment or timeout.
module riscv_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic                     clk,
    input logic                     reset,
    riscv_multicycle_ctrl_if.master bus
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpJal    = 7'h6F;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [31:0]     ir_q;
    logic [TmoW-1:0] tmo_q;
    logic            retired_q;
    logic            illegal_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] jump_tgt;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, is_alu, opcode_ok;
    logic        br_taken, br_bad, tmo_hit, active;
    logic        unused_alu_lsb;

    // Everything below decodes the latched ir only, never the raw fetch bus.
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign rd        = ir_q[11:7];
    assign imm_b     = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j     = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_tgt    = br_taken ? pc_q + imm_b : pc_plus4;
    assign jump_tgt  = is_jalr ? {bus.alu_result[31:1], 1'b0} : pc_q + imm_j;

    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_alu    = (opcode == OpReg) || (opcode == OpImm) || (opcode == OpLui) ||
                       (opcode == OpAuipc);
    assign opcode_ok = is_alu || is_load || is_store || is_branch || is_jal || is_jalr;
    assign tmo_hit   = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    assign unused_alu_lsb = bus.alu_result[0];

    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (funct3)
            3'b000:  br_taken = bus.alu_zero;
            3'b001:  br_taken = !bus.alu_zero;
            3'b100:  br_taken = bus.alu_lt;
            3'b101:  br_taken = !bus.alu_lt;
            3'b110:  br_taken = bus.alu_ltu;
            3'b111:  br_taken = !bus.alu_ltu;
            default: br_bad   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0013;
            tmo_q     <= '0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            retired_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (bus.imem_ready) begin
                        ir_q    <= bus.instruction;
                        tmo_q   <= '0;
                        state_q <= StDecode;
                    end else if (tmo_hit) begin
                        illegal_q <= 1'b1;
                        state_q   <= StTrap;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StDecode: begin
                    if (opcode_ok) begin
                        state_q <= StExec;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= StTrap;
                    end
                end
                StExec: begin
                    // Misaligned jumps trap here so the register file is never written.
                    if (is_branch) begin
                        if (br_bad || (br_tgt[1:0] != 2'b00)) begin
                            illegal_q <= 1'b1;
                            state_q   <= StTrap;
                        end else begin
                            pc_q      <= br_tgt;
                            retired_q <= 1'b1;
                            state_q   <= StFetch;
                        end
                    end else if ((is_jal || is_jalr) && (jump_tgt[1:0] != 2'b00)) begin
                        illegal_q <= 1'b1;
                        state_q   <= StTrap;
                    end else if (is_load || is_store) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (bus.dmem_ready) begin
                        tmo_q <= '0;
                        if (is_store) begin
                            pc_q      <= pc_plus4;
                            retired_q <= 1'b1;
                            state_q   <= StFetch;
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (tmo_hit) begin
                        illegal_q <= 1'b1;
                        state_q   <= StTrap;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StWb: begin
                    pc_q      <= (is_jal || is_jalr) ? jump_tgt : pc_plus4;
                    retired_q <= 1'b1;
                    state_q   <= StFetch;
                end
                StTrap: state_q <= StTrap;
                default: state_q <= StTrap;
            endcase
        end
    end

    assign active          = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);
    assign bus.pc          = pc_q;
    assign bus.ir          = ir_q;
    assign bus.retired     = retired_q;
    assign bus.illegal     = illegal_q;
    assign bus.imem_req    = (state_q == StFetch);
    assign bus.dmem_req    = (state_q == StMem);
    assign bus.dmem_we     = (state_q == StMem) && is_store;
    assign bus.reg_write   = (state_q == StWb) && (rd != 5'd0);
    assign bus.result_sel  = (state_q != StWb) ? 2'b00 :
                             is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
    assign bus.alu_src_imm = active && !((opcode == OpReg) || is_branch || is_jal);
    assign bus.alu_op      = !active ? 2'b00 : is_branch ? 2'b01 :
                             ((opcode == OpReg) || (opcode == OpImm)) ? 2'b10 : 2'b00;
endmodule
